// File: rtl/cam_pkg.sv
// Shared camera-pipeline definitions: colour class codes, RGB444 field
// positions and default screen geometry.
package cam_pkg;

  localparam int unsigned CAM_SCREEN_X_DEF = 160;
  localparam int unsigned CAM_SCREEN_Y_DEF = 120;

  // RGB444 field slices within a 12-bit pixel {R,G,B}
  localparam int unsigned RGB_R_HI = 11;
  localparam int unsigned RGB_R_LO = 8;
  localparam int unsigned RGB_G_HI = 7;
  localparam int unsigned RGB_G_LO = 4;
  localparam int unsigned RGB_B_HI = 3;
  localparam int unsigned RGB_B_LO = 0;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'b00,
    CLS_RED   = 2'b01,
    CLS_GREEN = 2'b10,
    CLS_BLUE  = 2'b11
  } cls_e;

endpackage

// File: rtl/color_frame_stats_if.sv
// Pixel tap and result port bundle for color_frame_stats.
interface color_frame_stats_if #(
  parameter int unsigned DW = 12,
  parameter int unsigned CW = 15,
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 7
);

  logic          vsync;
  logic          px_valid;
  logic [DW-1:0] px_data;
  logic [1:0]    sel_color;
  logic          result_ready;

  logic [CW-1:0] cnt_red;
  logic [CW-1:0] cnt_green;
  logic [CW-1:0] cnt_blue;
  logic [1:0]    dominant;
  logic [XW-1:0] bbox_xmin;
  logic [XW-1:0] bbox_xmax;
  logic [YW-1:0] bbox_ymin;
  logic [YW-1:0] bbox_ymax;
  logic          bbox_found;
  logic          result_valid;
  logic          result_overrun;
  logic          frame_err;

  // Camera/consumer side
  modport master (
    output vsync, px_valid, px_data, sel_color, result_ready,
    input  cnt_red, cnt_green, cnt_blue, dominant,
           bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, bbox_found,
           result_valid, result_overrun, frame_err
  );

  // Statistics block side
  modport slave (
    input  vsync, px_valid, px_data, sel_color, result_ready,
    output cnt_red, cnt_green, cnt_blue, dominant,
           bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, bbox_found,
           result_valid, result_overrun, frame_err
  );

endinterface

// File: rtl/rgb444_classifier.sv
// Combinational RGB444 colour classifier: one channel at or above th_hi
// while the other two are at or below th_lo selects that colour.
module rgb444_classifier
  import cam_pkg::*;
#(
  parameter int unsigned DW = 12
) (
  input  logic [DW-1:0] i_px,
  input  logic [3:0]    i_th_hi,
  input  logic [3:0]    i_th_lo,
  output cls_e          o_class_c
);

  logic [3:0] w_r;
  logic [3:0] w_g;
  logic [3:0] w_b;

  assign w_r = i_px[RGB_R_HI:RGB_R_LO];
  assign w_g = i_px[RGB_G_HI:RGB_G_LO];
  assign w_b = i_px[RGB_B_HI:RGB_B_LO];

  // Threshold test per channel, first match wins
  always_comb begin
    o_class_c = CLS_NONE;
    if (w_r >= i_th_hi && w_g <= i_th_lo && w_b <= i_th_lo) begin
      o_class_c = CLS_RED;
    end else if (w_g >= i_th_hi && w_r <= i_th_lo && w_b <= i_th_lo) begin
      o_class_c = CLS_GREEN;
    end else if (w_b >= i_th_hi && w_r <= i_th_lo && w_g <= i_th_lo) begin
      o_class_c = CLS_BLUE;
    end
  end

endmodule

// File: rtl/color_frame_stats.sv
// Per-frame colour statistics on the camera pixel-write stream.
// Counts red/green/blue pixels per frame and reports counts plus the
// dominant colour through a valid/ready result port at frame end.
// Optional target bounding box built when COLOR_STATS_BBOX_EN is defined;
// otherwise the bbox outputs are tied to 0.
module color_frame_stats
  import cam_pkg::*;
#(
  parameter int unsigned DW           = 12,
  parameter int unsigned CAM_SCREEN_X = CAM_SCREEN_X_DEF,
  parameter int unsigned CAM_SCREEN_Y = CAM_SCREEN_Y_DEF,
  parameter int unsigned CW           = 15,
  parameter int unsigned XW           = 8,
  parameter int unsigned YW           = 7,
  parameter logic [3:0]  TH_HI        = 4'd10,
  parameter logic [3:0]  TH_LO        = 4'd5
) (
  input  logic               clk,
  input  logic               rst,
  color_frame_stats_if.slave io_stats
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_ACCUM = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [CW-1:0] r_acc_red;
  logic [CW-1:0] r_acc_green;
  logic [CW-1:0] r_acc_blue;
  logic [CW-1:0] w_acc_red_nxt;
  logic [CW-1:0] w_acc_green_nxt;
  logic [CW-1:0] w_acc_blue_nxt;
  cls_e          w_class;
  cls_e          w_dom;

  logic          w_start;
  logic          w_pix;
  logic          w_x_end;
  logic          w_y_end;
  logic          w_last;
  logic          w_abort;

  logic [CW-1:0] r_cnt_red;
  logic [CW-1:0] r_cnt_green;
  logic [CW-1:0] r_cnt_blue;
  logic [1:0]    r_dominant;
  logic          r_valid;
  logic          r_overrun;
  logic          r_frame_err;

  rgb444_classifier #(
    .DW (DW)
  ) u_classifier (
    .i_px      (io_stats.px_data),
    .i_th_hi   (TH_HI),
    .i_th_lo   (TH_LO),
    .o_class_c (w_class)
  );

  assign w_start = (r_state == ST_SYNC) && !io_stats.vsync;
  assign w_pix   = (r_state == ST_ACCUM) && io_stats.px_valid;
  assign w_x_end = (r_x == XW'(CAM_SCREEN_X - 1));
  assign w_y_end = (r_y == YW'(CAM_SCREEN_Y - 1));
  assign w_last  = w_pix && w_x_end && w_y_end;
  // The final pixel takes priority over a coincident vsync rise
  assign w_abort = (r_state == ST_ACCUM) && io_stats.vsync && !w_last;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (io_stats.vsync) w_state_nxt = ST_SYNC;
      ST_SYNC:  if (!io_stats.vsync) w_state_nxt = ST_ACCUM;
      ST_ACCUM: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end else if (io_stats.vsync) begin
          w_state_nxt = ST_SYNC;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Pixel position within the frame
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pix) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Saturating class counters including the current pixel
  always_comb begin
    w_acc_red_nxt   = r_acc_red;
    w_acc_green_nxt = r_acc_green;
    w_acc_blue_nxt  = r_acc_blue;
    if (w_pix) begin
      case (w_class)
        CLS_RED:   if (!(&r_acc_red))   w_acc_red_nxt   = r_acc_red + CW'(1);
        CLS_GREEN: if (!(&r_acc_green)) w_acc_green_nxt = r_acc_green + CW'(1);
        CLS_BLUE:  if (!(&r_acc_blue))  w_acc_blue_nxt  = r_acc_blue + CW'(1);
        default:   ;
      endcase
    end
  end

  // Class accumulators, cleared at frame start
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_acc_red   <= '0;
      r_acc_green <= '0;
      r_acc_blue  <= '0;
    end else begin
      r_acc_red   <= w_acc_red_nxt;
      r_acc_green <= w_acc_green_nxt;
      r_acc_blue  <= w_acc_blue_nxt;
    end
  end

  // Dominant colour of the completed frame; ties favour red, then green
  always_comb begin
    w_dom = CLS_NONE;
    if (w_acc_red_nxt >= w_acc_green_nxt && w_acc_red_nxt >= w_acc_blue_nxt &&
        w_acc_red_nxt != '0) begin
      w_dom = CLS_RED;
    end else if (w_acc_green_nxt >= w_acc_blue_nxt && w_acc_green_nxt != '0) begin
      w_dom = CLS_GREEN;
    end else if (w_acc_blue_nxt != '0) begin
      w_dom = CLS_BLUE;
    end
  end

  // Result registers and valid/ready handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_red   <= '0;
      r_cnt_green <= '0;
      r_cnt_blue  <= '0;
      r_dominant  <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_abort;
      if (w_last) begin
        r_cnt_red   <= w_acc_red_nxt;
        r_cnt_green <= w_acc_green_nxt;
        r_cnt_blue  <= w_acc_blue_nxt;
        r_dominant  <= w_dom;
        r_valid     <= 1'b1;
        if (r_valid && !io_stats.result_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && io_stats.result_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign io_stats.cnt_red        = r_cnt_red;
  assign io_stats.cnt_green      = r_cnt_green;
  assign io_stats.cnt_blue       = r_cnt_blue;
  assign io_stats.dominant       = r_dominant;
  assign io_stats.result_valid   = r_valid;
  assign io_stats.result_overrun = r_overrun;
  assign io_stats.frame_err      = r_frame_err;

`ifdef COLOR_STATS_BBOX_EN
  logic [1:0]    r_sel;
  logic [XW-1:0] r_run_xmin;
  logic [XW-1:0] r_run_xmax;
  logic [YW-1:0] r_run_ymin;
  logic [YW-1:0] r_run_ymax;
  logic          r_run_found;
  logic [XW-1:0] w_run_xmin_nxt;
  logic [XW-1:0] w_run_xmax_nxt;
  logic [YW-1:0] w_run_ymin_nxt;
  logic [YW-1:0] w_run_ymax_nxt;
  logic          w_run_found_nxt;
  logic          w_hit;
  logic [XW-1:0] r_bbox_xmin;
  logic [XW-1:0] r_bbox_xmax;
  logic [YW-1:0] r_bbox_ymin;
  logic [YW-1:0] r_bbox_ymax;
  logic          r_bbox_found;

  assign w_hit = w_pix && (r_sel != CLS_NONE) && (w_class == r_sel);

  // Running extent including the current target pixel
  always_comb begin
    w_run_xmin_nxt  = r_run_xmin;
    w_run_xmax_nxt  = r_run_xmax;
    w_run_ymin_nxt  = r_run_ymin;
    w_run_ymax_nxt  = r_run_ymax;
    w_run_found_nxt = r_run_found;
    if (w_hit) begin
      if (r_x < r_run_xmin) w_run_xmin_nxt = r_x;
      if (r_x > r_run_xmax) w_run_xmax_nxt = r_x;
      if (r_y < r_run_ymin) w_run_ymin_nxt = r_y;
      if (r_y > r_run_ymax) w_run_ymax_nxt = r_y;
      w_run_found_nxt = 1'b1;
    end
  end

  // Running extent registers; target class latched for the whole frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel       <= '0;
      r_run_xmin  <= '0;
      r_run_xmax  <= '0;
      r_run_ymin  <= '0;
      r_run_ymax  <= '0;
      r_run_found <= 1'b0;
    end else if (w_start) begin
      r_sel       <= io_stats.sel_color;
      r_run_xmin  <= '1;
      r_run_xmax  <= '0;
      r_run_ymin  <= '1;
      r_run_ymax  <= '0;
      r_run_found <= 1'b0;
    end else begin
      r_run_xmin  <= w_run_xmin_nxt;
      r_run_xmax  <= w_run_xmax_nxt;
      r_run_ymin  <= w_run_ymin_nxt;
      r_run_ymax  <= w_run_ymax_nxt;
      r_run_found <= w_run_found_nxt;
    end
  end

  // Bounding box result, loaded alongside the counts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bbox_xmin  <= '0;
      r_bbox_xmax  <= '0;
      r_bbox_ymin  <= '0;
      r_bbox_ymax  <= '0;
      r_bbox_found <= 1'b0;
    end else if (w_last) begin
      r_bbox_xmin  <= w_run_xmin_nxt;
      r_bbox_xmax  <= w_run_xmax_nxt;
      r_bbox_ymin  <= w_run_ymin_nxt;
      r_bbox_ymax  <= w_run_ymax_nxt;
      r_bbox_found <= w_run_found_nxt;
    end
  end

  assign io_stats.bbox_xmin  = r_bbox_xmin;
  assign io_stats.bbox_xmax  = r_bbox_xmax;
  assign io_stats.bbox_ymin  = r_bbox_ymin;
  assign io_stats.bbox_ymax  = r_bbox_ymax;
  assign io_stats.bbox_found = r_bbox_found;
`else
  logic w_unused_sel;

  assign w_unused_sel        = ^io_stats.sel_color;
  assign io_stats.bbox_xmin  = '0;
  assign io_stats.bbox_xmax  = '0;
  assign io_stats.bbox_ymin  = '0;
  assign io_stats.bbox_ymax  = '0;
  assign io_stats.bbox_found = 1'b0;
`endif

endmodule

// File: tb/tb_color_frame_stats.sv
// Directed bench for color_frame_stats: a full-size instance for whole-frame
// scenarios and a small 8x4 instance for table-driven frame vectors.
module tb_color_frame_stats;

  localparam int unsigned DW = 12;
  localparam int unsigned CW = 15;
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned SX = 8;
  localparam int unsigned SY = 4;
  localparam int SN = SX * SY;
  localparam int unsigned FX = 160;
  localparam int unsigned FY = 120;
  localparam int FN = FX * FY;

  logic clk = 1'b0;
  logic rst;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  color_frame_stats_if #(.DW(DW), .CW(CW), .XW(XW), .YW(YW)) if_full ();
  color_frame_stats_if #(.DW(DW), .CW(CW), .XW(XW), .YW(YW)) if_small ();

  color_frame_stats #(
    .DW(DW), .CAM_SCREEN_X(FX), .CAM_SCREEN_Y(FY), .CW(CW), .XW(XW), .YW(YW)
  ) dut_full (
    .clk(clk), .rst(rst), .io_stats(if_full)
  );

  color_frame_stats #(
    .DW(DW), .CAM_SCREEN_X(SX), .CAM_SCREEN_Y(SY), .CW(CW), .XW(XW), .YW(YW)
  ) dut_small (
    .clk(clk), .rst(rst), .io_stats(if_small)
  );

  typedef struct {
    string       name;
    int          n_red, n_green, n_blue, n_other;
    logic [11:0] d_red, d_green, d_blue, d_other;
    int          ready;
    int          e_red, e_green, e_blue, e_dom, e_valid, e_ovr, e_err;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic small_start();
    if_small.vsync = 1'b1;
    tick();
    tick();
    if_small.vsync = 1'b0;
    tick();
  endtask

  task automatic full_start();
    if_full.vsync = 1'b1;
    tick();
    tick();
    if_full.vsync = 1'b0;
    tick();
  endtask

  // Complete small frame of one pixel value; ready raised with the last pixel
  task automatic small_frame(input logic [11:0] d, input bit ready_on_last);
    small_start();
    for (int i = 0; i < SN; i++) begin
      if_small.px_valid = 1'b1;
      if_small.px_data  = d;
      if (i == SN - 1 && ready_on_last) if_small.result_ready = 1'b1;
      tick();
    end
    if_small.px_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int total;
    total = v.n_red + v.n_green + v.n_blue + v.n_other;
    if_small.result_ready = (v.ready != 0);
    small_start();
    for (int i = 0; i < total; i++) begin
      if_small.px_valid = 1'b1;
      if (i < v.n_red)                            if_small.px_data = v.d_red;
      else if (i < v.n_red + v.n_green)           if_small.px_data = v.d_green;
      else if (i < v.n_red + v.n_green + v.n_blue) if_small.px_data = v.d_blue;
      else                                        if_small.px_data = v.d_other;
      tick();
      // idle strobe gap carrying a red pixel that must not be counted
      if (i % 4 == 3 && i != total - 1) begin
        if_small.px_valid = 1'b0;
        if_small.px_data  = 12'hF00;
        tick();
      end
    end
    if_small.px_valid = 1'b0;
    if (total < SN) begin
      if_small.vsync = 1'b1;
      tick();
    end
    chk({v.name, ".red"},   32'(if_small.cnt_red),        v.e_red);
    chk({v.name, ".green"}, 32'(if_small.cnt_green),      v.e_green);
    chk({v.name, ".blue"},  32'(if_small.cnt_blue),       v.e_blue);
    chk({v.name, ".dom"},   32'(if_small.dominant),       v.e_dom);
    chk({v.name, ".valid"}, 32'(if_small.result_valid),   v.e_valid);
    chk({v.name, ".ovr"},   32'(if_small.result_overrun), v.e_ovr);
    chk({v.name, ".err"},   32'(if_small.frame_err),      v.e_err);
    chk({v.name, ".found"}, 32'(if_small.bbox_found),     0);
    tick();
    chk({v.name, ".err_next"},   32'(if_small.frame_err),    0);
    chk({v.name, ".valid_next"}, 32'(if_small.result_valid), (v.ready != 0) ? 0 : v.e_valid);
  endtask

  function automatic logic [11:0] full_px(input int mode, input int i);
    int x, y;
    x = i % FX;
    y = i / FX;
    case (mode)
      0:       return 12'hF00;
      1:       return (i < FN / 2) ? 12'h0F0 : 12'h00F;
      default: begin
        if ((x == 10 && y == 20) || (x == 100 && y == 50)) return 12'hF00;
        if ((x == 0 && y == 0) || (x == 150 && y == 110))  return 12'h0F0;
        return 12'h888;
      end
    endcase
  endfunction

  task automatic full_frame(input int mode, input string name);
    full_start();
    for (int i = 0; i < FN; i++) begin
      if_full.px_valid = 1'b1;
      if_full.px_data  = full_px(mode, i);
      if (i == FN - 1) chk({name, ".valid_before"}, 32'(if_full.result_valid), 0);
      tick();
    end
    if_full.px_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"red_full",  32, 0,  0,  0,  12'hF00, 12'h0F0, 12'h00F, 12'h888, 1, 32, 0,  0,  1, 1, 0, 0};
    vecs[1] = '{"tie_gb",    0,  16, 16, 0,  12'hF00, 12'h0F0, 12'h00F, 12'h888, 1, 0,  16, 16, 2, 1, 0, 0};
    vecs[2] = '{"mix_edge",  3,  3,  2,  24, 12'hA55, 12'h5A5, 12'h55A, 12'h888, 1, 3,  3,  2,  1, 1, 0, 0};
    vecs[3] = '{"blue_win",  1,  2,  5,  24, 12'hF00, 12'h0F0, 12'h00F, 12'h955, 1, 1,  2,  5,  3, 1, 0, 0};
    vecs[4] = '{"abort",     5,  0,  0,  0,  12'hF00, 12'h0F0, 12'h00F, 12'h888, 1, 1,  2,  5,  3, 0, 0, 1};
    vecs[5] = '{"all_other", 0,  0,  0,  32, 12'hF00, 12'h0F0, 12'h00F, 12'hA65, 1, 0,  0,  0,  0, 1, 0, 0};
    vecs[6] = '{"hold1",     32, 0,  0,  0,  12'hF00, 12'h0F0, 12'h00F, 12'h888, 0, 32, 0,  0,  1, 1, 0, 0};
    vecs[7] = '{"hold2",     0,  32, 0,  0,  12'hF00, 12'h0F0, 12'h00F, 12'h888, 0, 0,  32, 0,  2, 1, 1, 0};

    rst = 1'b1;
    if_full.vsync = 1'b0;  if_full.px_valid = 1'b0;  if_full.px_data = '0;
    if_full.sel_color = 2'b00;  if_full.result_ready = 1'b1;
    if_small.vsync = 1'b0; if_small.px_valid = 1'b0; if_small.px_data = '0;
    if_small.sel_color = 2'b00; if_small.result_ready = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;

    chk("rst.small_red",   32'(if_small.cnt_red),        0);
    chk("rst.small_dom",   32'(if_small.dominant),       0);
    chk("rst.small_valid", 32'(if_small.result_valid),   0);
    chk("rst.small_ovr",   32'(if_small.result_overrun), 0);
    chk("rst.small_err",   32'(if_small.frame_err),      0);
    chk("rst.full_valid",  32'(if_full.result_valid),    0);
    chk("rst.full_xmin",   32'(if_full.bbox_xmin),       0);

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // overrun stays set after the held result is finally accepted
    if_small.result_ready = 1'b1;
    tick();
    chk("accept.valid", 32'(if_small.result_valid),   0);
    chk("accept.ovr",   32'(if_small.result_overrun), 1);

    // reset in the middle of a frame
    if_small.result_ready = 1'b0;
    small_start();
    for (int i = 0; i < 10; i++) begin
      if_small.px_valid = 1'b1;
      if_small.px_data  = 12'hF00;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.red",   32'(if_small.cnt_red),        0);
    chk("midrst.green", 32'(if_small.cnt_green),      0);
    chk("midrst.dom",   32'(if_small.dominant),       0);
    chk("midrst.valid", 32'(if_small.result_valid),   0);
    chk("midrst.ovr",   32'(if_small.result_overrun), 0);
    // pixels before the next frame start are ignored
    for (int i = 0; i < 40; i++) tick();
    if_small.px_valid = 1'b0;
    chk("ignored.valid", 32'(if_small.result_valid), 0);
    chk("ignored.red",   32'(if_small.cnt_red),      0);
    small_frame(12'h00F, 1'b0);
    chk("post.blue",  32'(if_small.cnt_blue),     32);
    chk("post.red",   32'(if_small.cnt_red),      0);
    chk("post.dom",   32'(if_small.dominant),     3);
    chk("post.valid", 32'(if_small.result_valid), 1);
    // accept and new load in the same cycle: no overrun
    small_frame(12'hF00, 1'b1);
    chk("same.valid", 32'(if_small.result_valid),   1);
    chk("same.red",   32'(if_small.cnt_red),        32);
    chk("same.blue",  32'(if_small.cnt_blue),       0);
    chk("same.ovr",   32'(if_small.result_overrun), 0);
    tick();
    chk("same.valid_next", 32'(if_small.result_valid), 0);

    // full-size frame of red pixels
    if_full.result_ready = 1'b1;
    full_frame(0, "f_red");
    chk("f_red.valid", 32'(if_full.result_valid), 1);
    chk("f_red.red",   32'(if_full.cnt_red),      19200);
    chk("f_red.green", 32'(if_full.cnt_green),    0);
    chk("f_red.blue",  32'(if_full.cnt_blue),     0);
    chk("f_red.dom",   32'(if_full.dominant),     1);
    tick();
    chk("f_red.valid_next", 32'(if_full.result_valid), 0);

    // half green, half blue: tie goes to green
    full_frame(1, "f_gb");
    chk("f_gb.red",   32'(if_full.cnt_red),   0);
    chk("f_gb.green", 32'(if_full.cnt_green), 9600);
    chk("f_gb.blue",  32'(if_full.cnt_blue),  9600);
    chk("f_gb.dom",   32'(if_full.dominant),  2);
    tick();

    // bounding box of two red target pixels
    if_full.sel_color = 2'b01;
    full_frame(2, "f_bb");
    chk("f_bb.red",   32'(if_full.cnt_red),   2);
    chk("f_bb.green", 32'(if_full.cnt_green), 2);
    chk("f_bb.dom",   32'(if_full.dominant),  1);
`ifdef COLOR_STATS_BBOX_EN
    chk("f_bb.xmin",  32'(if_full.bbox_xmin),  10);
    chk("f_bb.xmax",  32'(if_full.bbox_xmax),  100);
    chk("f_bb.ymin",  32'(if_full.bbox_ymin),  20);
    chk("f_bb.ymax",  32'(if_full.bbox_ymax),  50);
    chk("f_bb.found", 32'(if_full.bbox_found), 1);
`else
    chk("f_bb.xmin",  32'(if_full.bbox_xmin),  0);
    chk("f_bb.xmax",  32'(if_full.bbox_xmax),  0);
    chk("f_bb.ymin",  32'(if_full.bbox_ymin),  0);
    chk("f_bb.ymax",  32'(if_full.bbox_ymax),  0);
    chk("f_bb.found", 32'(if_full.bbox_found), 0);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
